sdu_hex_tx: RTL

UART hex-print transmitter for the serial debug unit. Accepts one 32-bit debug word (PC, IR, register or memory data) per handshake and sends it on `txd` as 8 uppercase ASCII hex characters, followed by a space or CR LF, in 8N1 framing. It is the transmit-side counterpart of the SDU command receiver and drives the SDU's `txd` pin.

---
 rtl/sdu_hex_tx.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/sdu_hex_tx.sv
// UART hex-print transmitter: sends a 32-bit word as 8 uppercase ASCII hex
// characters plus a space or CR LF terminator, 8N1, one bit per DIV clocks.
module sdu_hex_tx #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 115200
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        valid,
    input  logic [31:0] data,
    input  logic        eol,
    output logic        ready,
    output logic        done,
    output logic        txd
);

    localparam int DIV = CLK_FREQ / BAUD;
    localparam int BW  = $clog2(DIV);
    localparam logic [BW-1:0] BAUD_LAST = BW'(DIV - 1);
    localparam logic [BW-1:0] BAUD_ONE  = BW'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [BW-1:0]  baud_q, baud_d;
    logic [2:0]     bit_q, bit_d;
    logic [3:0]     idx_q, idx_d;
    logic [31:0]    word_q, word_d;
    logic           eol_q, eol_d;
    logic           txd_q, txd_d;
    logic           ready_q, ready_d;
    logic           done_q, done_d;

    logic [31:0]    shifted_s;
    logic [7:0]     char_s;
    logic           last_char_s;
    logic           baud_end_s;

    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            hex_ascii = {4'h3, nib};
        end else begin
            hex_ascii = 8'h37 + {4'h0, nib};
        end
    endfunction

    // Character currently on the wire: hex nibble for index 0..7, terminator after.
    always_comb begin
        shifted_s = word_q << {idx_q[2:0], 2'b00};
        if (idx_q < 4'd8) begin
            char_s = hex_ascii(shifted_s[31:28]);
        end else if (!eol_q) begin
            char_s = 8'h20;
        end else if (idx_q == 4'd8) begin
            char_s = 8'h0D;
        end else begin
            char_s = 8'h0A;
        end
        last_char_s = eol_q ? (idx_q == 4'd9) : (idx_q == 4'd8);
        baud_end_s  = (baud_q == BAUD_LAST);
    end

    // Next-state logic; txd/ready/done are computed one cycle ahead and registered.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        idx_d   = idx_q;
        word_d  = word_q;
        eol_d   = eol_q;
        txd_d   = txd_q;
        ready_d = ready_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (valid && ready_q) begin
                    state_d = S_START;
                    word_d  = data;
                    eol_d   = eol;
                    idx_d   = 4'd0;
                    bit_d   = 3'd0;
                    baud_d  = '0;
                    txd_d   = 1'b0;
                    ready_d = 1'b0;
                end else begin
                    txd_d   = 1'b1;
                    ready_d = 1'b1;
                end
            end
            S_START: begin
                if (baud_end_s) begin
                    state_d = S_DATA;
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    txd_d   = char_s[0];
                end else begin
                    baud_d  = baud_q + BAUD_ONE;
                end
            end
            S_DATA: begin
                if (baud_end_s) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                        txd_d   = 1'b1;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        txd_d   = char_s[bit_q + 3'd1];
                    end
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            S_STOP: begin
                if (baud_end_s) begin
                    baud_d = '0;
                    if (last_char_s) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                        ready_d = 1'b1;
                        txd_d   = 1'b1;
                    end else begin
                        // Next character starts immediately, no idle gap.
                        state_d = S_START;
                        idx_d   = idx_q + 4'd1;
                        txd_d   = 1'b0;
                    end
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                baud_d  = '0;
                bit_d   = 3'd0;
                idx_d   = 4'd0;
                txd_d   = 1'b1;
                ready_d = 1'b1;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= 3'd0;
            idx_q   <= 4'd0;
            word_q  <= 32'h0;
            eol_q   <= 1'b0;
            txd_q   <= 1'b1;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
            eol_q   <= eol_d;
            txd_q   <= txd_d;
            ready_q <= ready_d;
            done_q  <= done_d;
        end
    end

    assign txd   = txd_q;
    assign ready = ready_q;
    assign done  = done_q;

endmodule
